// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encoding, NOP word and the word-align helper.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return i_addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating wait counter for an outstanding memory request.
// o_tc flags the last cycle allowed before timeout (count == MAX_WAIT-1).
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] TC_VAL  = W'(MAX_WAIT - 1);
    localparam logic [W-1:0] SAT_VAL = W'(MAX_WAIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC sample, req/ack memory read, hold for decode.
// Optional misaligned-PC fault when IFETCH_ALIGN_CHECK_EN is defined.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int          MAX_WAIT    = 15,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        Stall,
    output logic        TimeoutErr,
    output logic        FetchFault
);

    fetch_state_t r_state, w_state_nx;
    logic         r_req, w_req_nx;
    logic [31:0]  r_addr, w_addr_nx;
    logic [31:0]  r_instr, w_instr_nx;
    logic         r_valid, w_valid_nx;
    logic         r_tmo, w_tmo_nx;
    logic         w_tc;
    logic         w_clr;
    logic         w_inc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic         r_fault, w_fault_nx;
`endif

    assign w_clr = (r_state == IDLE);
    assign w_inc = (r_state == REQ) || (r_state == DROP);

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .i_clk   (Clock),
        .i_rst_n (Reset_L),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_tc    (w_tc)
    );

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_instr <= RESET_INSTR;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_addr  <= w_addr_nx;
            r_instr <= w_instr_nx;
            r_valid <= w_valid_nx;
            r_tmo   <= w_tmo_nx;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_fault <= w_fault_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_addr_nx  = r_addr;
        w_instr_nx = r_instr;
        w_valid_nx = r_valid;
        w_tmo_nx   = r_tmo;
`ifdef IFETCH_ALIGN_CHECK_EN
        w_fault_nx = r_fault;
`endif
        unique case (r_state)
            IDLE: begin
                if (!Flush) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    // A fault parks the stage in IDLE until reset.
                    if (r_fault || (PC[1:0] != 2'b00)) begin
                        w_fault_nx = 1'b1;
                    end else
`endif
                    begin
                        w_addr_nx  = word_align(PC);
                        w_req_nx   = 1'b1;
                        w_state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (MemAck && !Flush) begin
                    w_instr_nx = MemData;
                    w_valid_nx = 1'b1;
                    w_req_nx   = 1'b0;
                    w_state_nx = HOLD;
                end else if (MemAck) begin
                    w_req_nx   = 1'b0;
                    w_state_nx = IDLE;
                end else if (Flush) begin
                    w_state_nx = DROP;
                end else if (w_tc) begin
                    w_tmo_nx   = 1'b1;
                    w_req_nx   = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            DROP: begin
                // Keep the handshake alive until memory answers, then discard.
                if (MemAck) begin
                    w_req_nx   = 1'b0;
                    w_state_nx = IDLE;
                end else if (w_tc) begin
                    w_tmo_nx   = 1'b1;
                    w_req_nx   = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            HOLD: begin
                if (Flush) begin
                    w_valid_nx = 1'b0;
                    w_instr_nx = RESET_INSTR;
                    w_state_nx = IDLE;
                end else if (InstrReady) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign MemReq     = r_req;
    assign MemAddr    = r_addr;
    assign Instr      = r_instr;
    assign InstrValid = r_valid;
    assign TimeoutErr = r_tmo;
    assign Stall      = !((r_state == HOLD) && InstrReady && !Flush);
`ifdef IFETCH_ALIGN_CHECK_EN
    assign FetchFault = r_fault;
`else
    assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with an expected-instruction queue.
// Covers reset, wait states, flushes, timeout, throughput and alignment.
module tb_instr_fetch;

    logic        Clock;
    logic        Reset_L;
    logic [31:0] PC;
    logic        Flush;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        Stall;
    logic        TimeoutErr;
    logic        FetchFault;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    instr_fetch dut (
        .Clock      (Clock),
        .Reset_L    (Reset_L),
        .PC         (PC),
        .Flush      (Flush),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemData    (MemData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Stall      (Stall),
        .TimeoutErr (TimeoutErr),
        .FetchFault (FetchFault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        Reset_L    = 1'b0;
        Flush      = 1'b0;
        MemAck     = 1'b0;
        MemData    = '0;
        InstrReady = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clock);
        Reset_L = 1'b1;
    endtask

    task automatic test_reset();
        PC = 32'h0040_0000;
        do_reset();
        Reset_L = 1'b0;
        #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", MemAddr); end
        n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", Instr); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", InstrValid); end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got %b want 1", Stall); end
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_err++; $display("FAIL rst_tmo got %b want 0", TimeoutErr); end
        n_cmp++; if (FetchFault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b want 0", FetchFault); end
        // asynchronous reset while a request is outstanding
        @(negedge Clock);
        Reset_L = 1'b1;
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got %b want 1", MemReq); end
        #2 Reset_L = 1'b0;
        #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL rst_mid_req got %b want 0", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0) begin n_err++; $display("FAIL rst_mid_addr got %h want 0", MemAddr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset();
        PC = 32'h0040_0000;
        InstrReady = 1'b1;
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL zw_req got %b want 1", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0040_0000) begin n_err++; $display("FAIL zw_addr got %h want 00400000", MemAddr); end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL zw_stall_req got %b want 1", Stall); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL zw_valid_req got %b want 0", InstrValid); end
        MemAck  = 1'b1;
        MemData = 32'h8C08_0004;
        exp_q.push_back(32'h8C08_0004);
        @(negedge Clock);
        MemAck = 1'b0;
        #1;
        n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL zw_valid got %b want 1", InstrValid); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL zw_queue empty");
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (Instr !== e) begin n_err++; $display("FAIL zw_instr got %h want %h", Instr, e); end
        end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL zw_stall got %b want 0", Stall); end
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL zw_req_drop got %b want 0", MemReq); end
        @(negedge Clock); #1;
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL zw_valid_once got %b want 0", InstrValid); end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL zw_stall_after got %b want 1", Stall); end
    endtask

    task automatic test_wait3();
        logic [31:0] e;
        do_reset();
        PC = 32'h0040_0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock); #1;
            n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL w3_req[%0d] got %b want 1", k, MemReq); end
            n_cmp++; if (MemAddr !== 32'h0040_0010) begin n_err++; $display("FAIL w3_addr[%0d] got %h want 00400010", k, MemAddr); end
            n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL w3_early[%0d] got %b want 0", k, InstrValid); end
            if (k == 3) begin
                MemAck  = 1'b1;
                MemData = 32'h1234_5678;
                exp_q.push_back(32'h1234_5678);
            end
        end
        @(negedge Clock);
        MemAck = 1'b0;
        #1;
        n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL w3_valid got %b want 1", InstrValid); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL w3_queue empty");
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (Instr !== e) begin n_err++; $display("FAIL w3_instr got %h want %h", Instr, e); end
        end
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_err++; $display("FAIL w3_tmo got %b want 0", TimeoutErr); end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL w3_stall_noready got %b want 1", Stall); end
        // spurious ack while holding must not disturb the held word
        MemAck  = 1'b1;
        MemData = 32'hFFFF_0000;
        @(negedge Clock);
        MemAck = 1'b0;
        #1;
        n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL w3_hold_valid got %b want 1", InstrValid); end
        n_cmp++; if (Instr !== 32'h1234_5678) begin n_err++; $display("FAIL w3_hold_instr got %h want 12345678", Instr); end
        InstrReady = 1'b1;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL w3_stall_ready got %b want 0", Stall); end
        @(negedge Clock); #1;
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL w3_consumed got %b want 0", InstrValid); end
    endtask

    task automatic test_flush_req();
        do_reset();
        PC = 32'h0040_0020;
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL fr_req got %b want 1", MemReq); end
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        PC    = 32'h0040_0100;
        #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL fr_drop_req got %b want 1", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0040_0020) begin n_err++; $display("FAIL fr_drop_addr got %h want 00400020", MemAddr); end
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL fr_drop_req2 got %b want 1", MemReq); end
        MemAck  = 1'b1;
        MemData = 32'hDEAD_BEEF;
        @(negedge Clock);
        MemAck = 1'b0;
        #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL fr_req_drop got %b want 0", MemReq); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL fr_valid got %b want 0", InstrValid); end
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL fr_new_req got %b want 1", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0040_0100) begin n_err++; $display("FAIL fr_new_addr got %h want 00400100", MemAddr); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL fr_valid2 got %b want 0", InstrValid); end
        // flush together with ack in REQ goes straight back to IDLE
        Flush   = 1'b1;
        MemAck  = 1'b1;
        MemData = 32'hBAD0_BAD0;
        @(negedge Clock);
        Flush  = 1'b0;
        MemAck = 1'b0;
        #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL fa_req got %b want 0", MemReq); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL fa_valid got %b want 0", InstrValid); end
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL fa_reissue got %b want 1", MemReq); end
    endtask

    task automatic test_flush_hold();
        logic [31:0] e;
        do_reset();
        PC = 32'h0040_0030;
        @(negedge Clock);
        MemAck  = 1'b1;
        MemData = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        @(negedge Clock);
        MemAck = 1'b0;
        #1;
        n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL fh_valid got %b want 1", InstrValid); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL fh_queue empty");
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (Instr !== e) begin n_err++; $display("FAIL fh_instr got %h want %h", Instr, e); end
        end
        Flush      = 1'b1;
        InstrReady = 1'b1;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL fh_stall got %b want 1", Stall); end
        @(negedge Clock);
        Flush      = 1'b0;
        InstrReady = 1'b0;
        #1;
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL fh_valid_clr got %b want 0", InstrValid); end
        n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL fh_instr_nop got %h want 0", Instr); end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL fh_stall_after got %b want 1", Stall); end
    endtask

    task automatic test_timeout();
        do_reset();
        PC = 32'h0040_0040;
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clock); #1;
            n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL to_req[%0d] got %b want 1", k, MemReq); end
            n_cmp++; if (TimeoutErr !== 1'b0) begin n_err++; $display("FAIL to_early[%0d] got %b want 0", k, TimeoutErr); end
        end
        @(negedge Clock); #1;
        n_cmp++; if (TimeoutErr !== 1'b1) begin n_err++; $display("FAIL to_set got %b want 1", TimeoutErr); end
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL to_req_drop got %b want 0", MemReq); end
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL to_retry got %b want 1", MemReq); end
        n_cmp++; if (TimeoutErr !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", TimeoutErr); end
        Reset_L = 1'b0;
        #1;
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_err++; $display("FAIL to_reset got %b want 0", TimeoutErr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [31:0] d;
        int done;
        int last;
        done = 0;
        last = -1;
        do_reset();
        PC = 32'h0040_1000;
        InstrReady = 1'b1;
        for (int cyc = 0; cyc < 40 && done < 4; cyc++) begin
            @(negedge Clock); #1;
            if (InstrValid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL bb_queue empty");
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if (Instr !== e) begin n_err++; $display("FAIL bb_instr got %h want %h", Instr, e); end
                end
                n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL bb_stall got %b want 0", Stall); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last != 3) begin n_err++; $display("FAIL bb_rate got %0d want 3", cyc - last); end
                end
                last = cyc;
                done++;
                PC = PC + 32'd4;
            end
            MemAck = MemReq;
            if (MemReq) begin
                n_cmp++; if (MemAddr !== PC) begin n_err++; $display("FAIL bb_addr got %h want %h", MemAddr, PC); end
                d = $urandom;
                MemData = d;
                exp_q.push_back(d);
            end
        end
        MemAck = 1'b0;
        n_cmp++; if (done != 4) begin n_err++; $display("FAIL bb_count got %0d want 4", done); end
    endtask

    task automatic test_align();
        do_reset();
        PC = 32'h0040_0002;
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock); #1;
            n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL al_req[%0d] got %b want 0", k, MemReq); end
            n_cmp++; if (FetchFault !== 1'b1) begin n_err++; $display("FAIL al_fault[%0d] got %b want 1", k, FetchFault); end
            n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL al_stall[%0d] got %b want 1", k, Stall); end
            PC = 32'h0040_0004;
        end
        Reset_L = 1'b0;
        #1;
        n_cmp++; if (FetchFault !== 1'b0) begin n_err++; $display("FAIL al_reset got %b want 0", FetchFault); end
`else
        @(negedge Clock); #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL al_req got %b want 1", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0040_0000) begin n_err++; $display("FAIL al_addr got %h want 00400000", MemAddr); end
        n_cmp++; if (FetchFault !== 1'b0) begin n_err++; $display("FAIL al_fault got %b want 0", FetchFault); end
`endif
    endtask

    initial begin
        Reset_L    = 1'b0;
        PC         = '0;
        Flush      = 1'b0;
        MemAck     = 1'b0;
        MemData    = '0;
        InstrReady = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_flush_req();
        test_flush_hold();
        test_timeout();
        test_back_to_back();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
